// File: rtl/npc_ctrl.sv
// Next-PC controller: fetch PC register, branch/jump resolution, taken counter and misaligned-jr halt.
// Optional macro NPC_LIKELY_EN enables annulment of the bgezall delay slot on not-taken.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  br_op,
  input  logic        equ,
  input  logic [31:0] rd1,
  input  logic [31:0] imm32,
  input  logic [25:0] instr_index,
  input  logic [31:0] id_pc,
  output logic [31:0] pc_f,
  output logic [31:0] link_pc,
  output logic        redirect,
  output logic        flush_d,
  output logic        halt_err,
  output logic [15:0] taken_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [2:0] OP_BEQ     = 3'd1;
  localparam logic [2:0] OP_BLTZ    = 3'd2;
  localparam logic [2:0] OP_BGEZALL = 3'd3;
  localparam logic [2:0] OP_J       = 3'd4;
  localparam logic [2:0] OP_JAL     = 3'd5;
  localparam logic [2:0] OP_JR      = 3'd6;

  state_t      state;
  logic        take;
  logic        misaligned_jr;
  logic        active;
  logic [31:0] target;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign br_target = id_pc + 32'd4 + (imm32 << 2);
  assign j_target  = {id_pc[31:28], instr_index, 2'b00};

  always_comb begin
    take   = 1'b0;
    target = br_target;
    case (br_op)
      OP_BEQ:     take = equ;
      OP_BLTZ:    take = rd1[31];
      OP_BGEZALL: take = ~rd1[31];
      OP_J, OP_JAL: begin
        take   = 1'b1;
        target = j_target;
      end
      OP_JR: begin
        take   = 1'b1;
        target = rd1;
      end
      default: take = 1'b0;
    endcase
  end

  assign misaligned_jr = (br_op == OP_JR) && (rd1[1:0] != 2'b00);
  assign active        = (state == RUN) && !stall;
  assign redirect      = active && take && !misaligned_jr;
  assign link_pc       = id_pc + 32'd8;

`ifdef NPC_LIKELY_EN
  // Not-taken branch-likely annuls the delay slot already sitting in IF/ID.
  assign flush_d = active && (br_op == OP_BGEZALL) && rd1[31];
`else
  assign flush_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f      <= RESET_PC;
      state     <= RUN;
      halt_err  <= 1'b0;
      taken_cnt <= 16'd0;
    end else if (active) begin
      if (misaligned_jr) begin
        halt_err <= 1'b1;
        state    <= HALT;
      end else if (redirect) begin
        pc_f      <= target;
        taken_cnt <= taken_cnt + 16'd1;
      end else begin
        pc_f <= pc_f + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_npc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  br_op = 3'd0;
  logic        equ = 1'b0;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] imm32 = 32'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] id_pc = 32'd0;
  logic [31:0] pc_f;
  logic [31:0] link_pc;
  logic        redirect;
  logic        flush_d;
  logic        halt_err;
  logic [15:0] taken_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_halted;
  bit          m_err;
  bit          likely_build;

  npc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .br_op(br_op), .equ(equ),
    .rd1(rd1), .imm32(imm32), .instr_index(instr_index), .id_pc(id_pc),
    .pc_f(pc_f), .link_pc(link_pc), .redirect(redirect), .flush_d(flush_d),
    .halt_err(halt_err), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".pc_f"}, pc_f, m_pc);
    checkOutput({tag, ".taken_cnt"}, {16'd0, taken_cnt}, m_cnt % 65536);
    checkOutput({tag, ".halt_err"}, {31'd0, halt_err}, {31'd0, m_err});
  endtask

  // Drives one ID-stage decision, checks combinational outputs mid-cycle, then registered state after the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic [2:0] op, input logic e,
                               input logic [31:0] r, input logic [31:0] imm, input logic [25:0] idx,
                               input logic [31:0] ipc);
    bit          takes;
    bit          bad_jr;
    bit          exp_redirect;
    bit          exp_flush;
    logic [31:0] dest;
    stall = s; br_op = op; equ = e; rd1 = r; imm32 = imm; instr_index = idx; id_pc = ipc;
    #1;
    takes  = 0;
    dest   = 32'd0;
    if (op == 1 && e)            begin takes = 1; dest = ipc + 4 + imm * 4; end
    if (op == 2 && r[31])        begin takes = 1; dest = ipc + 4 + imm * 4; end
    if (op == 3 && !r[31])       begin takes = 1; dest = ipc + 4 + imm * 4; end
    if (op == 4 || op == 5)      begin takes = 1; dest = (ipc & 32'hF000_0000) | (idx * 4); end
    if (op == 6)                 begin takes = 1; dest = r; end
    bad_jr       = (op == 6) && (r % 4 != 0);
    exp_redirect = !m_halted && !s && takes && !bad_jr;
    exp_flush    = likely_build && !m_halted && !s && op == 3 && r[31];
    checkOutput({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_redirect});
    checkOutput({tag, ".flush_d"}, {31'd0, flush_d}, {31'd0, exp_flush});
    checkOutput({tag, ".link_pc"}, link_pc, ipc + 8);
    @(posedge clk);
    #1;
    if (!m_halted && !s) begin
      if (bad_jr) begin
        m_halted = 1;
        m_err    = 1;
      end else if (exp_redirect) begin
        m_pc = dest;
        m_cnt++;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    checkRegs(tag);
  endtask

  task automatic modelReset();
    m_pc = 32'h0000_3000; m_cnt = 0; m_halted = 0; m_err = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulseReset(input string tag);
    reset = 1'b0;
    #2;
    modelReset();
    checkRegs(tag);
    reset = 1'b1;
    #1;
  endtask

  initial begin
`ifdef NPC_LIKELY_EN
    likely_build = 1;
`else
    likely_build = 0;
`endif
    modelReset();
    #12;
    checkRegs("reset_hold");
    reset = 1'b1;
    #1;
    checkRegs("reset_release");
    applyStimulus("seq", 0, 3'd0, 0, 0, 0, 0, 32'h3000);
    checkOutput("seq.pc_3004", pc_f, 32'h3004);

    applyStimulus("beq_stall", 1, 3'd1, 1, 0, 32'd3, 0, 32'h3004);
    checkOutput("beq_stall.held", pc_f, 32'h3004);
    applyStimulus("beq", 0, 3'd1, 1, 0, 32'd3, 0, 32'h3004);
    checkOutput("beq.target", pc_f, 32'h3014);
    checkOutput("beq.cnt", {16'd0, taken_cnt}, 32'd1);
    applyStimulus("beq_nt", 0, 3'd1, 0, 0, 32'hFFFF_FFFE, 0, 32'h3014);
    applyStimulus("bltz_back", 0, 3'd2, 0, 32'h8000_0000, 32'hFFFF_FFFE, 0, 32'h3018);
    applyStimulus("rsvd", 0, 3'd7, 1, 0, 32'd5, 0, 32'h3018);

    applyStimulus("jal", 0, 3'd5, 0, 0, 0, 26'h0C04, 32'h3008);
    checkOutput("jal.target", pc_f, 32'h0000_3010);
    applyStimulus("bgezall_nt", 0, 3'd3, 0, 32'h8000_0000, 32'd4, 0, 32'h3010);
    applyStimulus("bgezall_t", 0, 3'd3, 0, 32'h0, 32'd4, 0, 32'h3014);
    checkOutput("bgezall_t.target", pc_f, 32'h3028);
    applyStimulus("jr_ok", 0, 3'd6, 0, 32'h0000_4000, 0, 0, 32'h3028);
    applyStimulus("jr_bad", 0, 3'd6, 0, 32'h3002, 0, 0, 32'h4000);
    checkOutput("jr_bad.halt_err", {31'd0, halt_err}, 32'd1);
    for (int i = 0; i < 6; i++)
      applyStimulus("halted", 1'($urandom_range(0, 1)), 3'($urandom_range(1, 6)), 1, 32'h0,
                    32'd1, 26'h100, 32'h5000);

    // Drive the counter to 16'hFFFF and confirm it wraps on the next taken jump.
    pulseReset("reset2");
    for (int i = 0; i < 65535; i++)
      applyStimulus("j_fill", 0, 3'd4, 0, 0, 0, 26'h0C00, 32'h3000);
    checkOutput("j_fill.cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);
    applyStimulus("j_wrap", 0, 3'd4, 0, 0, 0, 26'h0C00, 32'h3000);
    checkOutput("j_wrap.cnt", {16'd0, taken_cnt}, 32'd0);

    applyStimulus("stall_beq", 1, 3'd1, 1, 0, 32'd8, 0, 32'h3100);
    stall = 1'b1; br_op = 3'd1; equ = 1'b1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset.pc_f", pc_f, 32'h3000);
    modelReset();
    #1;
    reset = 1'b1;
    #1;
    applyStimulus("post_reset", 0, 3'd0, 0, 0, 0, 0, 32'h3000);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00;
      if (m_halted && $urandom_range(0, 3) == 0) pulseReset("rand_reset");
      applyStimulus("rand", 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), r, $urandom, 26'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
